// File: rtl/weight_streamer_if.sv
// Bundle of the burst-request, BRAM read and output stream signals of the
// weight streamer. The master modport is the streamer itself; the slave
// modport is the environment (requester, BRAM and stream consumer).
interface weight_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_address;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_address, count, readData, out_ready,
    output busy, done, readEnable, readAddress, out_data, out_valid
  );

  modport slave (
    output start, base_address, count, readData, out_ready,
    input  busy, done, readEnable, readAddress, out_data, out_valid
  );

endinterface

// File: rtl/weight_streamer.sv
// Burst reader: fetches `count` consecutive BRAM words starting at
// base_address (wrapping at the top of the address space) and streams them
// out through a 2-entry FIFO. Reads are throttled by a credit check so the
// FIFO plus the one-cycle BRAM pipeline can never hold more than 2 words.
module weight_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  weight_streamer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [ADDR_WIDTH:0]        remaining_q, remaining_d;
  logic                       in_flight_q, in_flight_d;
  logic                       zero_done_q, zero_done_d;
  logic [1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 occ_q, occ_d;

  logic [2:0] pending;
  logic       fifo_pop;
  logic       credit;
  logic       read_issue;
  logic       drain_done;

  // Per-cycle handshake terms: output pop, read credit and drain completion
  always_comb begin
    fifo_pop   = (occ_q != 2'd0) && bus.out_ready;
    pending    = {1'b0, occ_q} + {2'b00, in_flight_q};
    credit     = (pending < 3'd2) || ((pending == 3'd2) && fifo_pop);
    read_issue = (state_q == RUN) && (remaining_q != '0) && credit;
    drain_done = (state_q == DRAIN) && (occ_q == 2'd0) && !in_flight_q;
  end

  // Next-state logic: burst acceptance, address/remaining bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    in_flight_d = read_issue;
    case (state_q)
      IDLE: begin
        if (bus.start && !zero_done_q) begin
          if (bus.count != '0) begin
            state_d     = RUN;
            addr_d      = bus.base_address;
            remaining_d = bus.count;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (read_issue) begin
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO next state: the in-flight word lands at the tail, the head pops on transfer
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (in_flight_q) begin
      fifo_d[wr_ptr_q] = bus.readData;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (fifo_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({in_flight_q, fifo_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset abandons any burst and drops returning data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      zero_done_q <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      in_flight_q <= in_flight_d;
      zero_done_q <= zero_done_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = drain_done || zero_done_q;
  assign bus.readEnable  = read_issue;
  assign bus.readAddress = addr_q;
  assign bus.out_valid   = (occ_q != 2'd0);
  assign bus.out_data    = fifo_q[rd_ptr_q];

endmodule
